// File: rtl/int_narrow_packer.sv
// Saturating 32->16 narrowing packer: two lanes per output word, flush emits a partial word.
// Optional INT_PACK_SAT_FLAG_EN adds a per-lane sat_mask output registered with out_data.
module int_narrow_packer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_vld,
   output logic              in_rdy,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_signed,
   input  logic              out_signed,
   input  logic              flush,
   output logic              out_vld,
   input  logic              out_rdy,
   output logic [DATA_W-1:0] out_data,
`ifdef INT_PACK_SAT_FLAG_EN
   output logic [1:0]        sat_mask,
`endif
   output logic [1:0]        out_lane_vld
);

   localparam int LANE_W = DATA_W / 2;

   typedef enum logic {
      IDLE = 1'b0,
      HALF = 1'b1
   } state_t;

   // True when the source value is representable in the target lane type.
   function automatic logic lane_fits(input logic [DATA_W-1:0] d, input logic is_s, input logic os_s);
      logic fits;
      if (os_s) begin
         fits = (~|d[DATA_W-1:LANE_W-1]) | (is_s & (&d[DATA_W-1:LANE_W-1]));
      end else begin
         fits = (~|d[DATA_W-1:LANE_W]) & ~(is_s & d[DATA_W-1]);
      end
      return fits;
   endfunction

   // Saturated lane value; negative sources clamp low, everything else clamps high.
   function automatic logic [LANE_W-1:0] sat_value(input logic [DATA_W-1:0] d, input logic is_s, input logic os_s);
      logic              neg;
      logic [LANE_W-1:0] lane;
      neg = is_s & d[DATA_W-1];
      if (lane_fits(d, is_s, os_s)) begin
         lane = d[LANE_W-1:0];
      end else if (os_s) begin
         lane = neg ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
      end else begin
         lane = neg ? {LANE_W{1'b0}} : {LANE_W{1'b1}};
      end
      return lane;
   endfunction

   state_t            state;
   logic [LANE_W-1:0] half_q;
   logic              flush_pend_q;
   logic              slot_free;
   logic              accept;
   logic [LANE_W-1:0] beat_lane;
`ifdef INT_PACK_SAT_FLAG_EN
   logic              half_clamp_q;
   logic              beat_clamp;
`endif

   // Handshake decode and per-beat saturation.
   always_comb begin
      slot_free = ~out_vld | out_rdy;
      in_rdy    = slot_free & ~flush_pend_q & ~flush;
      accept    = in_vld & in_rdy;
      beat_lane = sat_value(in_data, in_signed, out_signed);
`ifdef INT_PACK_SAT_FLAG_EN
      beat_clamp = ~lane_fits(in_data, in_signed, out_signed);
`endif
   end

   // Pairing FSM and output word register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         half_q       <= {LANE_W{1'b0}};
         flush_pend_q <= 1'b0;
         out_vld      <= 1'b0;
         out_data     <= {DATA_W{1'b0}};
         out_lane_vld <= 2'b00;
`ifdef INT_PACK_SAT_FLAG_EN
         half_clamp_q <= 1'b0;
         sat_mask     <= 2'b00;
`endif
      end else begin
         if (out_vld & out_rdy) begin
            out_vld <= 1'b0;
         end else begin
            out_vld <= out_vld;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  half_q <= beat_lane;
`ifdef INT_PACK_SAT_FLAG_EN
                  half_clamp_q <= beat_clamp;
`endif
                  state  <= HALF;
               end else begin
                  state  <= IDLE;
               end
            end
            HALF: begin
               if (accept) begin
                  out_data     <= {beat_lane, half_q};
                  out_lane_vld <= 2'b11;
                  out_vld      <= 1'b1;
`ifdef INT_PACK_SAT_FLAG_EN
                  sat_mask     <= {beat_clamp, half_clamp_q};
`endif
                  state        <= IDLE;
               end else if (flush | flush_pend_q) begin
                  if (slot_free) begin
                     out_data     <= {{LANE_W{1'b0}}, half_q};
                     out_lane_vld <= 2'b01;
                     out_vld      <= 1'b1;
`ifdef INT_PACK_SAT_FLAG_EN
                     sat_mask     <= {1'b0, half_clamp_q};
`endif
                     flush_pend_q <= 1'b0;
                     state        <= IDLE;
                  end else begin
                     flush_pend_q <= 1'b1;
                  end
               end else begin
                  state <= HALF;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_narrow_packer.sv
// Randomized bench for int_narrow_packer against an arithmetic lane-queue reference model.
module tb_int_narrow_packer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_vld = 1'b0;
   logic        in_rdy;
   logic [31:0] in_data = 32'd0;
   logic        in_signed = 1'b0;
   logic        out_signed = 1'b0;
   logic        flush = 1'b0;
   logic        out_vld;
   logic        out_rdy = 1'b0;
   logic [31:0] out_data;
   logic [1:0]  out_lane_vld;
`ifdef INT_PACK_SAT_FLAG_EN
   logic [1:0]  sat_mask;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: a held lane (if any), a pending flush request, and a one-deep output slot.
   bit          m_has_half;
   logic [15:0] m_half;
   bit          m_half_clamp;
   bit          m_pend;
   bit          m_full;
   logic [31:0] m_word;
   logic [1:0]  m_lanes;
   logic [1:0]  m_mask;

   int_narrow_packer #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data),
      .in_signed(in_signed), .out_signed(out_signed), .flush(flush),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
`ifdef INT_PACK_SAT_FLAG_EN
      .sat_mask(sat_mask),
`endif
      .out_lane_vld(out_lane_vld)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Clamp the exact integer value into the target range.
   task automatic ref_sat(input logic [31:0] d, input bit is_s, input bit os_s,
                          output logic [15:0] lane, output bit clamped);
      longint v, lo, hi, r;
      v  = is_s ? longint'($signed(d)) : longint'(d);
      lo = os_s ? -64'sd32768 : 64'sd0;
      hi = os_s ? 64'sd32767 : 64'sd65535;
      r  = (v < lo) ? lo : ((v > hi) ? hi : v);
      clamped = (r != v);
      lane = r[15:0];
   endtask

   // Drive one cycle of inputs at the falling edge, check, advance the model over the rising edge.
   task automatic step(input bit r, input bit v, input logic [31:0] d, input bit is_s,
                       input bit os_s, input bit f, input bit ordy);
      bit          sf, exp_rdy, acc;
      logic [15:0] lane;
      bit          clamp;
      rst = r; in_vld = v; in_data = d; in_signed = is_s; out_signed = os_s;
      flush = f; out_rdy = ordy;
      #1;
      sf      = !m_full || ordy;
      exp_rdy = sf && !m_pend && !f;
      acc     = v && exp_rdy;
      check_val("in_rdy", {31'd0, in_rdy}, {31'd0, exp_rdy});
      check_val("out_vld", {31'd0, out_vld}, {31'd0, m_full});
      if (m_full) begin
         check_val("out_data", out_data, m_word);
         check_val("out_lane_vld", {30'd0, out_lane_vld}, {30'd0, m_lanes});
`ifdef INT_PACK_SAT_FLAG_EN
         check_val("sat_mask", {30'd0, sat_mask}, {30'd0, m_mask});
`endif
      end
      ref_sat(d, is_s, os_s, lane, clamp);
      if (r) begin
         m_has_half = 0; m_half = 16'd0; m_half_clamp = 0; m_pend = 0;
         m_full = 0; m_word = 32'd0; m_lanes = 2'b00; m_mask = 2'b00;
      end else begin
         if (m_full && ordy) m_full = 0;
         if (!m_has_half) begin
            if (acc) begin
               m_has_half = 1; m_half = lane; m_half_clamp = clamp;
            end
         end else if (acc) begin
            m_word = {lane, m_half}; m_lanes = 2'b11; m_mask = {clamp, m_half_clamp};
            m_full = 1; m_has_half = 0;
         end else if (f || m_pend) begin
            if (sf) begin
               m_word = {16'h0000, m_half}; m_lanes = 2'b01; m_mask = {1'b0, m_half_clamp};
               m_full = 1; m_has_half = 0; m_pend = 0;
            end else begin
               m_pend = 1;
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle(input bit ordy);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, ordy);
   endtask

   initial begin
      m_has_half = 0; m_half = 16'd0; m_half_clamp = 0; m_pend = 0;
      m_full = 0; m_word = 32'd0; m_lanes = 2'b00; m_mask = 2'b00;
      @(negedge clk);
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_val("rst_out_vld", {31'd0, out_vld}, 32'd0);
      check_val("rst_out_data", out_data, 32'd0);
      check_val("rst_lane_vld", {30'd0, out_lane_vld}, 32'd0);

      // In-range extremes pass straight through.
      step(1'b0, 1'b1, 32'h0000_7FFF, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'hFFFF_8000, 1'b1, 1'b1, 1'b0, 1'b1);
      check_val("t1_vld", {31'd0, out_vld}, 32'd1);
      check_val("t1_data", out_data, 32'h8000_7FFF);
      check_val("t1_lanes", {30'd0, out_lane_vld}, 32'd3);
`ifdef INT_PACK_SAT_FLAG_EN
      check_val("t1_mask", {30'd0, sat_mask}, 32'd0);
`endif
      step(1'b0, 1'b1, 32'h0000_8000, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b0, 1'b1);
      check_val("t2_data", out_data, 32'h0000_7FFF);
`ifdef INT_PACK_SAT_FLAG_EN
      check_val("t2_mask", {30'd0, sat_mask}, 32'd3);
`endif
      step(1'b0, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'h0000_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
      check_val("t3_data", out_data, 32'h7FFF_FFFF);
`ifdef INT_PACK_SAT_FLAG_EN
      check_val("t3_mask", {30'd0, sat_mask}, 32'd3);
`endif

      // Partial word on flush; flush with nothing held is ignored.
      step(1'b0, 1'b1, 32'h0000_1234, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_val("t4_vld", {31'd0, out_vld}, 32'd1);
      check_val("t4_data", out_data, 32'h0000_1234);
      check_val("t4_lanes", {30'd0, out_lane_vld}, 32'd1);
      idle(1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_val("t4_idle_flush", {31'd0, out_vld}, 32'd0);

      // Back-pressure holds the word and blocks further beats.
      step(1'b0, 1'b1, 32'h0000_0011, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0022, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h0000_0033, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(1'b0);
      check_val("t5_stable", out_data, 32'h0022_0011);
      step(1'b0, 1'b1, 32'h0000_0033, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_val("t5_partial", out_data, 32'h0000_0033);
      idle(1'b1);

      // Reset discards a held lane.
      step(1'b0, 1'b1, 32'h0000_5555, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_val("t6_rst_vld", {31'd0, out_vld}, 32'd0);
      step(1'b0, 1'b1, 32'd1, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b1, 32'd2, 1'b1, 1'b1, 1'b0, 1'b1);
      check_val("t6_data", out_data, 32'h0002_0001);

      // Random beats, config bits, flushes and stalls.
      for (int i = 0; i < 1000; i++) begin
         bit          f, v;
         logic [31:0] d;
         f = ($urandom_range(0, 9) == 0);
         v = f ? 1'b0 : ($urandom_range(0, 3) != 0);
         case ($urandom_range(0, 3))
            0: d = $urandom;
            1: d = $urandom_range(0, 70000);
            2: d = 32'hFFFF_0000 | $urandom_range(0, 65535);
            default: d = 32'h0000_7FF0 + $urandom_range(0, 31);
         endcase
         step(1'b0, v, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), f,
              ($urandom_range(0, 9) < 7));
      end
      for (int i = 0; i < 4; i++) idle(1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
